// File: rtl/wb_port_arbiter.sv
// Round-robin writeback arbiter. It grants one functional unit per cycle into a
// single registered writeback slot and flags requesters that stall too long.
module wb_port_arbiter #(
   parameter int NUM_UNITS       = 4,
   parameter int DATA_WIDTH      = 32,
   parameter int ID_WIDTH        = 3,
   parameter int PHYS_ADDR_WIDTH = 6,
   parameter int STARVE_LIMIT    = 15
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic [NUM_UNITS-1:0]                 unit_done,
   input  logic [NUM_UNITS*DATA_WIDTH-1:0]      unit_rd,
   input  logic [NUM_UNITS*ID_WIDTH-1:0]        unit_id,
   input  logic [NUM_UNITS*PHYS_ADDR_WIDTH-1:0] unit_phys_rd,
   output logic [NUM_UNITS-1:0]                 unit_ack,
   output logic                                 wb_valid,
   output logic [DATA_WIDTH-1:0]                wb_rd,
   output logic [ID_WIDTH-1:0]                  wb_id,
   output logic [PHYS_ADDR_WIDTH-1:0]           wb_phys_addr,
   input  logic                                 wb_ready,
   output logic                                 starved
);

   localparam int PTR_W = $clog2(NUM_UNITS);
   localparam logic [PTR_W-1:0] LAST_UNIT = PTR_W'(NUM_UNITS - 1);

   logic [PTR_W-1:0]           ptr_q, ptr_d;
   logic [7:0]                 waitCount_q, waitCount_d;
   logic                       wbValid_q, wbValid_d;
   logic [DATA_WIDTH-1:0]      wbRd_q, wbRd_d;
   logic [ID_WIDTH-1:0]        wbId_q, wbId_d;
   logic [PHYS_ADDR_WIDTH-1:0] wbPhys_q, wbPhys_d;
   logic                       starved_q, starved_d;

   logic                       canLoad;
   logic                       grantValid;
   logic [PTR_W-1:0]           grantIdx;
   int                         idx;

   // Scan from the round-robin pointer and grant the first requester, but only
   // when the slot is free or being drained this cycle.
   always_comb begin
      canLoad    = ~wbValid_q | wb_ready;
      grantValid = 1'b0;
      grantIdx   = '0;
      idx        = 0;
      unit_ack   = '0;
      if (!rst && !flush && canLoad) begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            idx = (int'(ptr_q) + i) % NUM_UNITS;
            if (!grantValid && unit_done[idx[PTR_W-1:0]]) begin
               grantValid = 1'b1;
               grantIdx   = idx[PTR_W-1:0];
            end
         end
      end
      if (grantValid) begin
         unit_ack[grantIdx] = 1'b1;
      end
   end

   always_comb begin
      wbValid_d   = wbValid_q;
      wbRd_d      = wbRd_q;
      wbId_d      = wbId_q;
      wbPhys_d    = wbPhys_q;
      ptr_d       = ptr_q;
      waitCount_d = waitCount_q;

      if (flush) begin
         wbValid_d = 1'b0;
      end else if (grantValid) begin
         wbValid_d = 1'b1;
         wbRd_d    = unit_rd[grantIdx*DATA_WIDTH +: DATA_WIDTH];
         wbId_d    = unit_id[grantIdx*ID_WIDTH +: ID_WIDTH];
         wbPhys_d  = unit_phys_rd[grantIdx*PHYS_ADDR_WIDTH +: PHYS_ADDR_WIDTH];
         ptr_d     = (grantIdx == LAST_UNIT) ? '0 : grantIdx + 1'b1;
      end else if (wb_ready) begin
         wbValid_d = 1'b0;
      end

      // A flushed cycle is invisible to the stall counter, so it neither counts nor clears.
      if (!flush) begin
         if (grantValid || unit_done == '0) begin
            waitCount_d = '0;
         end else if (waitCount_q != 8'hFF) begin
            waitCount_d = waitCount_q + 8'd1;
         end
      end

      starved_d = (int'(waitCount_d) >= STARVE_LIMIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbValid_q   <= 1'b0;
         wbRd_q      <= '0;
         wbId_q      <= '0;
         wbPhys_q    <= '0;
         ptr_q       <= '0;
         waitCount_q <= '0;
         starved_q   <= 1'b0;
      end else begin
         wbValid_q   <= wbValid_d;
         wbRd_q      <= wbRd_d;
         wbId_q      <= wbId_d;
         wbPhys_q    <= wbPhys_d;
         ptr_q       <= ptr_d;
         waitCount_q <= waitCount_d;
         starved_q   <= starved_d;
      end
   end

   assign wb_valid     = wbValid_q;
   assign wb_rd        = wbRd_q;
   assign wb_id        = wbId_q;
   assign wb_phys_addr = wbPhys_q;
   assign starved      = starved_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a vector table for the round-robin order
// plus hand sequences for backpressure/starvation, flush and async reset.
module tb_wb_port_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic [3:0]   unitDone;
   logic [127:0] unitRd;
   logic [11:0]  unitId;
   logic [23:0]  unitPhys;
   logic [3:0]   unitAck;
   logic         wbValid;
   logic [31:0]  wbRd;
   logic [2:0]   wbId;
   logic [5:0]   wbPhys;
   logic         wbReady;
   logic         starved;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] done;
      logic       ready;
      logic       fl;
      logic [3:0] ack;
      logic       valid;
      int         held;
      logic       starved;
   } vec_t;

   vec_t vecs[9];

   wb_port_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .unit_done    (unitDone),
      .unit_rd      (unitRd),
      .unit_id      (unitId),
      .unit_phys_rd (unitPhys),
      .unit_ack     (unitAck),
      .wb_valid     (wbValid),
      .wb_rd        (wbRd),
      .wb_id        (wbId),
      .wb_phys_addr (wbPhys),
      .wb_ready     (wbReady),
      .starved      (starved)
   );

   always #5 clk = ~clk;

   // Fixed per-unit payloads; unit index -1 stands for the cleared (reset) payload.
   function automatic logic [31:0] expRd(input int k);
      case (k)
         0:       return 32'hA0A0_0000;
         1:       return 32'hB1B1_1111;
         2:       return 32'hDEAD_BEEF;
         3:       return 32'hC3C3_3333;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [2:0] expId(input int k);
      return (k < 0) ? 3'd0 : 3'(k + 4);
   endfunction

   function automatic logic [5:0] expPhys(input int k);
      return (k < 0) ? 6'd0 : 6'(k + 16);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Drive one cycle: set inputs after the falling edge, check the combinational
   // grant before the rising edge, then check the registered state just after it.
   task automatic applyStimulus(input logic [3:0] done, input logic ready, input logic fl,
                                input logic [3:0] ack, input logic valid, input int held,
                                input logic expStarved, input string name);
      @(negedge clk);
      unitDone = done;
      wbReady  = ready;
      flush    = fl;
      #1;
      checkOutput({name, ".ack"}, 32'(unitAck), 32'(ack));
      @(posedge clk);
      #1;
      checkOutput({name, ".valid"}, 32'(wbValid), 32'(valid));
      checkOutput({name, ".rd"}, wbRd, expRd(held));
      checkOutput({name, ".id"}, 32'(wbId), 32'(expId(held)));
      checkOutput({name, ".phys"}, 32'(wbPhys), 32'(expPhys(held)));
      checkOutput({name, ".starved"}, 32'(starved), 32'(expStarved));
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         unitRd[k*32 +: 32]  = expRd(k);
         unitId[k*3 +: 3]    = expId(k);
         unitPhys[k*6 +: 6]  = expPhys(k);
      end

      // ptr starts at 0 after reset; each row notes the pointer after its edge.
      vecs[0] = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1,  2, 1'b0}; // single request, ptr=3
      vecs[1] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0,  2, 1'b0}; // drain, payload holds
      vecs[2] = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1,  3, 1'b0}; // wrap: unit 3, ptr=0
      vecs[3] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1,  0, 1'b0}; // then unit 0, ptr=1
      vecs[4] = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1,  1, 1'b0}; // all requesting from ptr=1
      vecs[5] = '{4'b1101, 1'b1, 1'b0, 4'b0100, 1'b1,  2, 1'b0};
      vecs[6] = '{4'b1001, 1'b1, 1'b0, 4'b1000, 1'b1,  3, 1'b0};
      vecs[7] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1,  0, 1'b0}; // fourth back-to-back, ptr=1
      vecs[8] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0,  0, 1'b0};

      rst      = 1'b1;
      flush    = 1'b0;
      wbReady  = 1'b1;
      unitDone = 4'b1111;
      #12;
      checkOutput("reset.ack", 32'(unitAck), 32'h0);
      checkOutput("reset.valid", 32'(wbValid), 32'h0);
      checkOutput("reset.rd", wbRd, 32'h0);
      checkOutput("reset.starved", 32'(starved), 32'h0);
      @(negedge clk);
      unitDone = 4'b0000;
      rst      = 1'b0;

      for (int v = 0; v < 9; v++) begin
         applyStimulus(vecs[v].done, vecs[v].ready, vecs[v].fl, vecs[v].ack,
                       vecs[v].valid, vecs[v].held, vecs[v].starved, $sformatf("vec%0d", v));
      end

      // Backpressure: fill the slot, then stall unit 1 for 20 cycles.
      applyStimulus(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 0, 1'b0, "bp.fill");
      for (int s = 1; s <= 20; s++) begin
         applyStimulus(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1, 0, (s >= 15),
                       $sformatf("bp.stall%0d", s));
      end
      applyStimulus(4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 1, 1'b0, "bp.release");
      applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1, 1'b0, "bp.drain");

      // Flush: held entry dropped without a grant; unit 0 wins the cycle after (ptr=3).
      applyStimulus(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2, 1'b0, "fl.fill");
      applyStimulus(4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 2, 1'b0, "fl.flush");
      applyStimulus(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 0, 1'b0, "fl.after");

      // Async reset between edges while an entry is held.
      @(negedge clk);
      unitDone = 4'b1111;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst.valid", 32'(wbValid), 32'h0);
      checkOutput("arst.rd", wbRd, 32'h0);
      checkOutput("arst.id", 32'(wbId), 32'h0);
      checkOutput("arst.ack", 32'(unitAck), 32'h0);
      @(negedge clk);
      rst      = 1'b0;
      unitDone = 4'b0000;
      applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 1'b0, "arst.idle");
      applyStimulus(4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 1, 1'b0, "arst.ptr0");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_UNITS, default 4, giving the number of writeback requesters (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the result data width.
REQ-003 The block SHALL have parameter ID_WIDTH, default 3, giving the instruction ID width.
REQ-004 The block SHALL have parameter PHYS_ADDR_WIDTH, default 6, giving the physical register address width.
REQ-005 The block SHALL have parameter STARVE_LIMIT, default 15, giving the stall-cycle threshold for the starvation flag (1..255).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have port flush, input, 1 bit: pipeline flush, discards the held writeback.
REQ-009 The block SHALL have port unit_done, input, NUM_UNITS bits: per-unit result-valid request.
REQ-010 The block SHALL have port unit_rd, input, NUM_UNITS x DATA_WIDTH: per-unit result data.
REQ-011 The block SHALL have port unit_id, input, NUM_UNITS x ID_WIDTH: per-unit instruction ID.
REQ-012 The block SHALL have port unit_phys_rd, input, NUM_UNITS x PHYS_ADDR_WIDTH: per-unit destination physical register.
REQ-013 The block SHALL have port unit_ack, output, NUM_UNITS bits: per-unit grant, combinational, at most one bit set.
REQ-014 The block SHALL have port wb_valid, output, 1 bit: a registered writeback is present.
REQ-015 The block SHALL have ports wb_rd, wb_id and wb_phys_addr, outputs of DATA_WIDTH, ID_WIDTH and PHYS_ADDR_WIDTH bits: the registered writeback payload.
REQ-016 The block SHALL have port wb_ready, input, 1 bit: the register file accepts wb_* this cycle.
REQ-017 The block SHALL have port starved, output, 1 bit: registered starvation flag.

Function
REQ-018 The block SHALL define can_load = ~wb_valid | wb_ready, evaluated with flush ignored.
REQ-019 unit_ack SHALL be all-zero whenever flush=1 or can_load=0.
REQ-020 Otherwise, unit_ack SHALL one-hot select the first set unit_done bit scanning ptr, ptr+1, ..., NUM_UNITS-1, 0, ..., ptr-1.
REQ-021 unit_ack SHALL be all-zero when unit_done is all-zero.
REQ-022 A requester SHALL hold unit_done and its payload stable until acked; the arbiter SHALL NOT latch anything without an ack.
REQ-023 On a cycle with ack to unit k, the block SHALL load wb_rd, wb_id and wb_phys_addr from unit k on the next edge and set wb_valid=1, giving one-cycle latency.
REQ-024 On a cycle with ack to unit k, ptr SHALL become (k+1) mod NUM_UNITS on the next edge, wrapping from NUM_UNITS-1 to 0.
REQ-025 ptr SHALL be unchanged on cycles without an ack.
REQ-026 If wb_valid=1 and wb_ready=1 with no ack, wb_valid SHALL clear and the payload SHALL hold its value.
REQ-027 If wb_valid=1 and wb_ready=0, all wb_* outputs SHALL hold unchanged.
REQ-028 Simultaneous accept and new grant SHALL replace the entry back-to-back, sustaining one writeback per cycle.
REQ-029 flush=1 SHALL clear wb_valid on the next edge regardless of wb_ready.
REQ-030 flush SHALL leave ptr, the payload registers and wait_count unchanged.
REQ-031 wait_count (8 bits) SHALL increment, saturating at 255, on cycles where unit_done≠0 and unit_ack=0.
REQ-032 wait_count SHALL reset to 0 on any ack or when unit_done=0.
REQ-033 starved SHALL be registered as (next wait_count ≥ STARVE_LIMIT).

Reset
REQ-034 While rst=1, the block SHALL force wb_valid=0, wb_rd=0, wb_id=0, wb_phys_addr=0, ptr=0, wait_count=0 and starved=0 asynchronously.
REQ-035 unit_ack SHALL be 0 while rst=1.
REQ-036 Reset asserted mid-stall SHALL discard the held entry; no writeback SHALL appear after release until a new ack.

Verification
REQ-037 Scenario "single request": reset, then unit_done=4'b0100, unit_rd=0xDEADBEEF, wb_ready=1 -> unit_ack=4'b0100 in the same cycle, next cycle wb_valid=1 and wb_rd=0xDEADBEEF, and ptr=3.
REQ-038 Scenario "all requesting": unit_done=4'b1111 held, with each acked unit dropping its request, wb_ready=1 -> acks in order 0,1,2,3, then wb_valid pulses on four consecutive cycles.
REQ-039 Scenario "wrap": ptr=3, unit_done=4'b1001 -> ack to unit 3, ptr becomes 0; next cycle ack to unit 0.
REQ-040 Scenario "backpressure": wb_valid=1, wb_ready=0 for 20 cycles with unit_done=4'b0010 -> no ack, wb_* stable, starved=1 from the 15th stall cycle; wb_ready=1 -> ack to unit 1 and starved clears the following cycle.
REQ-041 Scenario "flush": wb_valid=1, wb_ready=0, flush=1 with unit_done=4'b0001 -> no ack that cycle, next cycle wb_valid=0; ack to unit 0 the cycle after.
REQ-042 Scenario "async reset": rst pulsed between clock edges while wb_valid=1 -> wb_valid=0 immediately, before the next edge.
